// File: rtl/tl_frag_sink_ram.sv
// TileLink-UL scratchpad responder behind the 64-bit fragmenter.
// Single-beat A requests go through one stage register and a 3-entry FIFO, so D responses leave in request order.
module tl_frag_sink_ram #(
   parameter int DEPTH_WORDS = 512
) (
   input  logic        clock,
   input  logic        reset,
   output logic        auto_in_a_ready,
   input  logic        auto_in_a_valid,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [2:0]  auto_in_a_bits_param,
   input  logic [1:0]  auto_in_a_bits_size,
   input  logic [6:0]  auto_in_a_bits_source,
   input  logic [25:0] auto_in_a_bits_address,
   input  logic [7:0]  auto_in_a_bits_mask,
   input  logic [63:0] auto_in_a_bits_data,
   input  logic        auto_in_a_bits_corrupt,
   input  logic        auto_in_d_ready,
   output logic        auto_in_d_valid,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_size,
   output logic [6:0]  auto_in_d_bits_source,
   output logic [63:0] auto_in_d_bits_data
);

   localparam int AW     = $clog2(DEPTH_WORDS);
   localparam int DATA_W = 64;

   localparam logic [2:0] OP_PUT_FULL  = 3'd0;
   localparam logic [2:0] OP_PUT_PART  = 3'd1;
   localparam logic [2:0] OP_GET       = 3'd4;
   localparam logic [2:0] OP_ACK       = 3'd0;
   localparam logic [2:0] OP_ACK_DATA  = 3'd1;

   function automatic logic [1:0] f_ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
   endfunction

   logic              w_a_ready;
   logic              w_a_fire;
   logic              w_is_put;
   logic              w_is_get;
   logic              w_do_write;
   logic [AW-1:0]     w_idx;
   logic [2:0]        w_occupancy;
   logic [2:0]        w_rsp_op;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_push_data;
   logic              w_unused_ok;

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   logic              r_s1_vld_p1;
   logic [2:0]        r_s1_op_p1;
   logic [1:0]        r_s1_size_p1;
   logic [6:0]        r_s1_src_p1;
   logic [DATA_W-1:0] r_rd_data_p1;

   logic [2:0]        r_q_op   [3];
   logic [1:0]        r_q_size [3];
   logic [6:0]        r_q_src  [3];
   logic [DATA_W-1:0] r_q_data [3];
   logic [1:0]        r_wr_ptr;
   logic [1:0]        r_rd_ptr;
   logic [1:0]        r_q_count;

   // Ready depends only on registered occupancy: a request in flight in s1 already owns a FIFO slot.
   assign w_occupancy = {1'b0, r_q_count} + {2'b00, r_s1_vld_p1};
   assign w_a_ready   = (w_occupancy <= 3'd2);
   assign w_a_fire    = auto_in_a_valid & w_a_ready;

   assign w_is_put   = (auto_in_a_bits_opcode == OP_PUT_FULL) || (auto_in_a_bits_opcode == OP_PUT_PART);
   assign w_is_get   = (auto_in_a_bits_opcode == OP_GET);
   assign w_do_write = w_a_fire & w_is_put & ~auto_in_a_bits_corrupt;
   assign w_idx      = auto_in_a_bits_address[3 +: AW];
   assign w_rsp_op   = w_is_get ? OP_ACK_DATA : OP_ACK;

   assign w_unused_ok = &{1'b0, auto_in_a_bits_param, auto_in_a_bits_address[25:3+AW],
                          auto_in_a_bits_address[2:0]};

   // Stage p0 -> p1: memory access on the accept edge
   always_ff @(posedge clock) begin
      for (int i = 0; i < 8; i++) begin
         if (w_do_write && auto_in_a_bits_mask[i]) begin
            r_mem[w_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
         end
      end
      if (w_a_fire && w_is_get) begin
         r_rd_data_p1 <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_vld_p1 <= 1'b0;
      end else begin
         r_s1_vld_p1 <= w_a_fire;
      end
   end

   always_ff @(posedge clock) begin
      if (w_a_fire) begin
         r_s1_op_p1   <= w_rsp_op;
         r_s1_size_p1 <= auto_in_a_bits_size;
         r_s1_src_p1  <= auto_in_a_bits_source;
      end
   end

   // Stage p1 -> FIFO: the response is enqueued the cycle after accept
   assign w_push      = r_s1_vld_p1;
   assign w_pop       = (r_q_count != 2'd0) & auto_in_d_ready;
   assign w_push_data = (r_s1_op_p1 == OP_ACK_DATA) ? r_rd_data_p1 : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr  <= 2'd0;
         r_rd_ptr  <= 2'd0;
         r_q_count <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_q_count <= r_q_count + 2'd1;
            2'b01:   r_q_count <= r_q_count - 2'd1;
            default: r_q_count <= r_q_count;
         endcase
      end
   end

   // Entries are cleared on reset so the idle D bits read as zero.
   always_ff @(posedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            r_q_op[i]   <= '0;
            r_q_size[i] <= '0;
            r_q_src[i]  <= '0;
            r_q_data[i] <= '0;
         end else if (w_push && (r_wr_ptr == 2'(i))) begin
            r_q_op[i]   <= r_s1_op_p1;
            r_q_size[i] <= r_s1_size_p1;
            r_q_src[i]  <= r_s1_src_p1;
            r_q_data[i] <= w_push_data;
         end
      end
   end

   always_comb begin
      auto_in_d_bits_opcode = r_q_op[2];
      auto_in_d_bits_size   = r_q_size[2];
      auto_in_d_bits_source = r_q_src[2];
      auto_in_d_bits_data   = r_q_data[2];
      case (r_rd_ptr)
         2'd0: begin
            auto_in_d_bits_opcode = r_q_op[0];
            auto_in_d_bits_size   = r_q_size[0];
            auto_in_d_bits_source = r_q_src[0];
            auto_in_d_bits_data   = r_q_data[0];
         end
         2'd1: begin
            auto_in_d_bits_opcode = r_q_op[1];
            auto_in_d_bits_size   = r_q_size[1];
            auto_in_d_bits_source = r_q_src[1];
            auto_in_d_bits_data   = r_q_data[1];
         end
         default: ;
      endcase
   end

   assign auto_in_a_ready = w_a_ready;
   assign auto_in_d_valid = (r_q_count != 2'd0);

endmodule
